// File: rtl/op_sequencer.sv
// Command-queued sequencer for a shared datapath unit: buffers op codes, issues
// them one at a time over a start/finish handshake, counts completions, flags timeouts.
module op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_sel,
  output logic             cmd_ready,
  input  logic             en,
  input  logic             finish,
  input  logic             clr_err,
  output logic             start,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state, state_n;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop;
  logic [TW-1:0]   timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (en && !empty && !timeout_err) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      // finish takes priority over an expiring timer in the same cycle
      S_WAIT: begin
        if (finish)               state_n = S_DONE;
        else if (timer == T_LAST) state_n = S_ERR;
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    cmd_ready = !full;
    push      = cmd_valid && !full;
    pop       = (state == S_IDLE) && (state_n == S_ISSUE);
    busy      = (state != S_IDLE) || !empty;
  end

  // Command FIFO: payload storage needs no reset, only the pointers do
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Handshake outputs are registered from the next state so they are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      start       <= 1'b0;
      done        <= 1'b0;
      sel         <= 3'd0;
      timeout_err <= 1'b0;
      op_count    <= '0;
    end else begin
      if (state == S_ISSUE)
        timer <= '0;
      else if ((state == S_WAIT) && !finish && (timer != T_LAST))
        timer <= timer + 1'b1;
      start <= (state_n == S_ISSUE);
      done  <= (state_n == S_DONE);
      if (pop) sel <= mem[rd_ptr];
      if (state == S_ERR)  timeout_err <= 1'b1;
      else if (clr_err)    timeout_err <= 1'b0;
      if (state == S_DONE) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_op_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [2:0]       cmd_sel;
  logic             cmd_ready;
  logic             en;
  logic             finish;
  logic             clr_err;
  logic             start;
  logic [2:0]       sel;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] op_count;

  op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_sel(cmd_sel),
    .cmd_ready(cmd_ready), .en(en), .finish(finish), .clr_err(clr_err),
    .start(start), .sel(sel), .busy(busy), .done(done),
    .timeout_err(timeout_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending queue plus "cycles since launch" of the op in flight
  int mq[$];
  int mk;          // 0: no op in flight, 1: launch cycle, n>=2: (n-1)-th wait cycle
  bit m_done;      // completion cycle
  bit m_errc;      // timeout cycle
  bit m_terr;
  int m_cnt;
  int m_sel;

  int n_start = 0;
  int n_done  = 0;
  int cyc     = 0;
  int issued[$];
  int start_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    mk     = 0;
    m_done = 1'b0;
    m_errc = 1'b0;
    m_terr = 1'b0;
    m_cnt  = 0;
    m_sel  = 0;
  endfunction

  task automatic model_edge();
    int nk, ncnt, nsel;
    bit nd, ne, nt, idle, can_push, issue;
    if (rst) begin
      model_reset();
      return;
    end
    idle     = (mk == 0) && !m_done && !m_errc;
    can_push = cmd_valid && (mq.size() < DEPTH);
    issue    = idle && en && (mq.size() > 0) && !m_terr;
    nk = mk; nd = 1'b0; ne = 1'b0; ncnt = m_cnt; nsel = m_sel; nt = m_terr;
    if (m_done) ncnt = (m_cnt + 1) % (1 << CNT_W);
    if (m_errc) nt = 1'b1;
    else if (clr_err) nt = 1'b0;
    if (mk == 1) nk = 2;
    else if (mk >= 2) begin
      if (finish)                  begin nk = 0; nd = 1'b1; end
      else if (mk - 1 == TIMEOUT)  begin nk = 0; ne = 1'b1; end
      else                         nk = mk + 1;
    end
    if (issue) begin
      nsel = mq.pop_front();
      nk   = 1;
    end
    if (can_push) mq.push_back(int'(cmd_sel));
    mk = nk; m_done = nd; m_errc = ne; m_terr = nt; m_cnt = ncnt; m_sel = nsel;
  endtask

  task automatic check_all();
    chk("start",       32'(start),       32'(mk == 1));
    chk("done",        32'(done),        32'(m_done));
    chk("sel",         32'(sel),         32'(m_sel));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("op_count",    32'(op_count),    32'(m_cnt));
    chk("cmd_ready",   32'(cmd_ready),   32'(mq.size() < DEPTH));
    chk("busy",        32'(busy),        32'((mk != 0) || m_done || m_errc || (mq.size() != 0)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (start) begin
      n_start++;
      issued.push_back(int'(sel));
      start_cyc.push_back(cyc);
    end
    if (done) n_done++;
    check_all();
  endtask

  task automatic push_cmd(input int code);
    cmd_valid = 1'b1;
    cmd_sel   = 3'(code);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20 && !start; i++) step();
    chk("wait_start", 32'(start), 32'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && busy; i++) step();
    chk("drain_busy", 32'(busy), 32'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"},     32'(start),       32'(0));
    chk({tag, "_done"},      32'(done),        32'(0));
    chk({tag, "_sel"},       32'(sel),         32'(0));
    chk({tag, "_busy"},      32'(busy),        32'(0));
    chk({tag, "_terr"},      32'(timeout_err), 32'(0));
    chk({tag, "_opcnt"},     32'(op_count),    32'(0));
    chk({tag, "_cmd_ready"}, 32'(cmd_ready),   32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, s0, d0, saved;
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 3'd0; en = 1'b0; finish = 1'b0; clr_err = 1'b0;
    model_reset();
    #12;
    chk_reset_outputs("por");
    #1 rst = 1'b0;

    // Single op: launch latency, held sel, one done, op_count=1
    en = 1'b1;
    push_cmd(5);
    k = cyc;
    wait_start();
    chk("single_latency", 32'(cyc - k), 32'(1));
    step();
    step();
    finish = 1'b1;
    step();
    chk("single_done", 32'(done), 32'(1));
    finish = 1'b0;
    step();
    chk("single_sel", 32'(sel), 32'(5));
    chk("single_opcnt", 32'(op_count), 32'(1));
    chk("single_nstart", 32'(n_start), 32'(1));
    chk("single_ndone", 32'(n_done), 32'(1));

    // Queue full: fifth push dropped, then back-to-back at 4 cycles per op
    en = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(i);
    chk("full_ready", 32'(cmd_ready), 32'(0));
    push_cmd(5);
    issued.delete();
    start_cyc.delete();
    finish = 1'b1;
    en = 1'b1;
    drain();
    chk("full_nissued", 32'(issued.size()), 32'(4));
    for (int i = 0; i < issued.size(); i++) chk("full_code", 32'(issued[i]), 32'(i + 1));
    for (int i = 1; i < start_cyc.size(); i++)
      chk("full_period", 32'(start_cyc[i] - start_cyc[i-1]), 32'(4));
    chk("full_opcnt", 32'(op_count), 32'(5));

    // en gating: nothing issues while low; in-flight op completes after en drops
    finish = 1'b0;
    en = 1'b0;
    push_cmd(7);
    push_cmd(2);
    s0 = n_start;
    repeat (5) step();
    chk("en_block", 32'(n_start), 32'(s0));
    en = 1'b1;
    wait_start();
    chk("en_first_sel", 32'(sel), 32'(7));
    en = 1'b0;
    step();
    step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    repeat (6) step();
    chk("en_one_start", 32'(n_start), 32'(s0 + 1));
    chk("en_busy_held", 32'(busy), 32'(1));
    chk("en_opcnt", 32'(op_count), 32'(6));
    issued.delete();
    en = 1'b1;
    finish = 1'b1;
    drain();
    chk("en_resume_n", 32'(issued.size()), 32'(1));
    chk("en_resume_sel", 32'(sel), 32'(2));

    // Timeout: sticky error, count unchanged, queue retained until clr_err
    finish = 1'b0;
    en = 1'b0;
    push_cmd(3);
    push_cmd(4);
    push_cmd(6);
    saved = int'(op_count);
    s0 = n_start;
    d0 = n_done;
    en = 1'b1;
    repeat (12) step();
    chk("to_err", 32'(timeout_err), 32'(1));
    chk("to_opcnt", 32'(op_count), 32'(saved));
    chk("to_nstart", 32'(n_start), 32'(s0 + 1));
    chk("to_ndone", 32'(n_done), 32'(d0));
    chk("to_busy", 32'(busy), 32'(1));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("to_cleared", 32'(timeout_err), 32'(0));
    issued.delete();
    finish = 1'b1;
    drain();
    chk("to_nissued", 32'(issued.size()), 32'(2));
    if (issued.size() == 2) begin
      chk("to_code0", 32'(issued[0]), 32'(4));
      chk("to_code1", 32'(issued[1]), 32'(6));
    end

    // finish on the last permitted wait cycle beats the timeout
    finish = 1'b0;
    push_cmd(5);
    wait_start();
    repeat (TIMEOUT) step();
    finish = 1'b1;
    step();
    chk("coll_done", 32'(done), 32'(1));
    chk("coll_terr", 32'(timeout_err), 32'(0));
    finish = 1'b0;
    step();
    step();

    // Async reset mid-wait with two commands still queued
    en = 1'b0;
    push_cmd(1);
    push_cmd(2);
    push_cmd(3);
    en = 1'b1;
    wait_start();
    step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_reset_outputs("midrst");
    s0 = n_start;
    d0 = n_done;
    #3 rst = 1'b0;
    repeat (4) step();
    chk("midrst_nostart", 32'(n_start), 32'(s0));
    chk("midrst_nodone", 32'(n_done), 32'(d0));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_sel   = 3'($urandom_range(0, 7));
      en        = ($urandom_range(0, 7) != 0);
      finish    = ($urandom_range(0, 3) == 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      step();
    end
    cmd_valid = 1'b0;
    clr_err = 1'b0;
    finish = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Command-queued controller that sequences a single shared datapath unit through its start/finish handshake. It buffers up to DEPTH 3-bit operation-select codes and issues them one at a time: it drives `sel` and a one-cycle `start`, then waits for `finish`. It counts completed operations and flags a sticky error if the unit does not finish within TIMEOUT cycles. It sits between the command source (switches/host logic) and the datapath unit's FSM.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max WAIT cycles without `finish` before error (≥1)
- CNT_W, 8, width of completed-operation counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present on cmd_sel
- cmd_sel  in  3  operation code to queue
- cmd_ready  out  1  FIFO can accept; = !full (combinational from FIFO state)
- en  in  1  issue enable; low blocks new issues only
- finish  in  1  datapath unit completion, level, sampled in WAIT only
- clr_err  in  1  clears timeout_err
- start  out  1  one-cycle registered launch pulse to datapath
- sel  out  3  operation code to datapath, registered
- busy  out  1  state≠IDLE or FIFO non-empty
- done  out  1  one-cycle pulse per successful completion
- timeout_err  out  1  sticky timeout flag
- op_count  out  CNT_W  completed operations, wraps modulo 2^CNT_W

## Operation
- FIFO: push on cmd_valid && cmd_ready; pop only on IDLE→ISSUE transition. Push while full is dropped (cmd_ready=0). Push and pop in the same cycle are both performed; when full, cmd_ready stays 0 that cycle. Pointers wrap modulo DEPTH.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: if en && !empty && !timeout_err → ISSUE, load FIFO head into `sel`, pop. Otherwise stay.
- ISSUE: start=1, wait timer cleared → WAIT. finish is ignored.
- WAIT: if finish → DONE. Else if timer == TIMEOUT−1 → ERR. Else timer+1. finish wins over timeout in the same cycle. Low en does not abort.
- DONE: done=1, op_count+1 (wraps) → IDLE.
- ERR: set timeout_err → IDLE. No issues while timeout_err=1; queued commands are retained.
- clr_err clears timeout_err in any state. If ERR sets timeout_err in the same cycle as clr_err, the set wins.
- `sel` holds its value from ISSUE until the next issue.
- finish is ignored outside WAIT. Unsupported encodings don't exist: all 8 codes pass through unchanged.

## Timing
- Reset (async assert, any state): state=IDLE, FIFO empty, timer=0. start=0, sel=0, done=0, busy=0, timeout_err=0, op_count=0. cmd_ready=1.
- Command accepted at edge k into an empty FIFO with en=1: start high in the cycle after edge k+1. That is one idle cycle, then start.
- finish sampled high at edge m in WAIT: done high for the cycle after edge m, and op_count updates at edge m+1.
- Minimum back-to-back period: 4 cycles per operation (ISSUE, WAIT, DONE, IDLE), with finish high in the first WAIT cycle.
- Timeout: exactly TIMEOUT WAIT cycles with finish=0 → ERR for one cycle, then timeout_err=1 from the following cycle.
- Reset mid-WAIT: the operation is abandoned, queued commands are lost, and start/done are not reasserted.

## Test plan
- Reset/idle: assert rst mid-WAIT with 2 queued → all outputs 0, cmd_ready=1, busy=0 immediately (async).
- Single op: push sel=3'b101, finish high 3 cycles after start → one start pulse, sel=5 held, one done pulse, op_count=1.
- Queue full/back-to-back: push 5 codes 1..5 with finish held low → cmd_ready=0 after 4, 5th dropped. Then hold finish=1 → codes 1,2,3,4 issued every 4 cycles, op_count=4, busy falls after last DONE.
- en gating: queue 2 ops, en=0 → no start; drop en mid-WAIT → the current op completes and the next one is not issued until en=1.
- Timeout: TIMEOUT=4, finish never → ERR after 4 WAIT cycles, timeout_err=1, op_count unchanged, remaining queue held. Pulse clr_err → next op issues.
- Finish/timeout collision: finish rises on the TIMEOUT-th WAIT cycle → DONE, timeout_err stays 0.
